threshold_comparator_seq: RTL and testbench
===========================================

// Module: threshold_comparator_seq
// PURPOSE
//  Registered, parametrised successor of the 4-bit combinational word comparator.
//  - Compares a WIDTH-bit input sample against a run-time loadable threshold in one of four modes.
//  - Applies a persistence filter so out changes only after PERSIST consecutive agreeing samples.
//  - Flags edges of out and counts rising events for status/debug logic downstream.
// PARAMETERS
//  WIDTH        4        sample/threshold width, >=1
//  THR_DEFAULT  4'b0111  threshold value after reset, WIDTH bits
//  PERSIST      3        consecutive valid samples required to change out, >=1
//  CNT_W        8        width of rising-event counter
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      in_word is a sample this cycle
//  in_word    in   WIDTH  sample, unsigned
//  mode       in   2      cmp_mode_t: 00 EQ, 01 GT, 10 GE, 11 LT (in_word OP threshold)
//  thr_load   in   1      load thr_value into threshold register
//  thr_value  in   WIDTH  new threshold
//  cnt_clr    in   1      clear evt_cnt
//  out        out  1      filtered compare result, registered
//  out_valid  out  1      sticky: 1 from cycle after first accepted sample
//  rise       out  1      1-cycle pulse, out went 0->1 this cycle
//  fall       out  1      1-cycle pulse, out went 1->0 this cycle
//  evt_cnt    out  CNT_W  number of rise pulses, saturating
// BEHAVIOUR
//  - Reset (sync, overrides all inputs incl. thr_load/cnt_clr):
//    out=0, out_valid=0, rise=0, fall=0, evt_cnt=0, thr_q=THR_DEFAULT, state=LOW, pcnt=0.
//  - raw = (in_word OP thr_q), unsigned, evaluated only when in_valid=1; mode sampled with the sample.
//  - thr_load: thr_q<=thr_value at edge; same-cycle sample uses OLD thr_q.
//  - FSM: LOW, PEND_HI, HIGH, PEND_LO; pcnt counts disagreeing samples.
//    - LOW: raw=1 -> PERSIST==1 ? HIGH : PEND_HI with pcnt=1.
//    - PEND_HI: raw=1 -> pcnt+1; on reaching PERSIST -> HIGH, pcnt=0. raw=0 -> LOW, pcnt=0.
//    - HIGH/PEND_LO: mirror image with raw=0.
//    - in_valid=0: state and pcnt hold; gaps do not break a run.
//  - out=1 in HIGH and PEND_LO, else 0; registered.
//  - Latency: out changes at the edge sampling the PERSIST-th consecutive sample; visible next cycle.
//  - rise/fall: asserted exactly in the first cycle out shows its new value; never both.
//  - evt_cnt: +1 per rise; saturates at all-ones.
//    cnt_clr same cycle as rise -> evt_cnt=0 (clear wins).
//  - out_valid: set at first in_valid edge after reset; cleared only by rst.
//  - Reset mid-run discards partial pcnt; a new run starts from LOW.
// CONFIGURATION
//  Macro CMP_HYSTERESIS_EN.
//  - Defined: adds input hyst[WIDTH-1:0].
//    - While out=1, deassert comparisons use thr_eff for GT/GE: thr_eff = thr_q - hyst, saturating at 0.
//    - While out=1, LT uses thr_eff = thr_q + hyst, saturating at all-ones.
//    - EQ ignores hyst. While out=0, thr_eff = thr_q.
//  - Undefined: no hyst port; thr_eff = thr_q always.
// STRUCTURE
//  - Package cmp_pkg: typedef enum cmp_mode_t {CMP_EQ, CMP_GT, CMP_GE, CMP_LT};
//    FSM state enum filt_state_t; function cmp_eval(a, b, mode).
//  - Sub-module persist_filter: FSM + pcnt, takes raw/raw_valid, produces out/rise/fall.
//  - Top keeps threshold register, compare, evt_cnt, out_valid.
// TESTING (WIDTH=4, THR_DEFAULT=7, PERSIST=3, CNT_W=8)
//  1. Reset, mode=GT; samples 8,9,10 each cycle -> out=1 and rise=1 in cycle after 10.
//     Then evt_cnt=1, out_valid=1 since cycle after first sample.
//  2. Mode=GT, out=1; samples 3,3,9,3,3,3 -> out stays 1 until third consecutive 3.
//     The 9 restarts the run; fall pulses once.
//  3. thr_load=1 with thr_value=2 in the same cycle as sample 5 (GT), old thr 7:
//     - that sample is raw=0;
//     - subsequent samples 5,5,5 -> out=1.
//  4. Mode=EQ, thr=7; samples 7, gap (in_valid=0 x4), 7, 7 -> out=1.
//     Gaps hold the run.
//  5. Force 255 rises; one more rise -> evt_cnt holds 255.
//     cnt_clr coincident with a rise -> evt_cnt=0.
//  6. rst asserted in PEND_HI after 2 matches -> all outputs reset next cycle.
//     thr_q=7; one further match leaves out=0.
//     With CMP_HYSTERESIS_EN, hyst=2, GT, out=1: sample 6 keeps raw=1; 5,5,5 -> out=0.

Source files
------------

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - compare modes, filter states and the compare helper.
package cmp_pkg;

  localparam int CMP_MAX_W = 32;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_GE = 2'b10,
    CMP_LT = 2'b11
  } cmp_mode_t;

  typedef enum logic [1:0] {
    ST_LOW     = 2'b00,
    ST_PEND_HI = 2'b01,
    ST_HIGH    = 2'b10,
    ST_PEND_LO = 2'b11
  } filt_state_t;

  // Operands are zero-extended by the caller, so this is an unsigned compare.
  function automatic logic cmp_eval(input logic [CMP_MAX_W-1:0] a,
                                    input logic [CMP_MAX_W-1:0] b,
                                    input cmp_mode_t mode);
    logic r;
    case (mode)
      CMP_EQ:  r = (a == b);
      CMP_GT:  r = (a > b);
      CMP_GE:  r = (a >= b);
      default: r = (a < b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/persist_filter.sv
// rtl/persist_filter.sv - persistence FSM: out flips after PERSIST consecutive disagreeing samples.
module persist_filter
  import cmp_pkg::*;
#(
  parameter int PERSIST = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic raw_valid,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int PCNT_W = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERSIST);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

  filt_state_t       state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d, pcnt_inc;
  logic              out_q, out_d;
  logic              rise_q, fall_q;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    pcnt_inc = pcnt_q + PCNT_ONE;
    case (state_q)
      ST_LOW: begin
        if (raw_valid && raw) begin
          if (PERSIST == 1) begin
            state_d = ST_HIGH;
          end else begin
            state_d = ST_PEND_HI;
            pcnt_d  = PCNT_ONE;
          end
        end
      end
      ST_PEND_HI: begin
        if (raw_valid) begin
          if (!raw) begin
            state_d = ST_LOW;
            pcnt_d  = '0;
          end else if (pcnt_inc == PCNT_LAST) begin
            state_d = ST_HIGH;
            pcnt_d  = '0;
          end else begin
            pcnt_d  = pcnt_inc;
          end
        end
      end
      ST_HIGH: begin
        if (raw_valid && !raw) begin
          if (PERSIST == 1) begin
            state_d = ST_LOW;
          end else begin
            state_d = ST_PEND_LO;
            pcnt_d  = PCNT_ONE;
          end
        end
      end
      default: begin
        if (raw_valid) begin
          if (raw) begin
            state_d = ST_HIGH;
            pcnt_d  = '0;
          end else if (pcnt_inc == PCNT_LAST) begin
            state_d = ST_LOW;
            pcnt_d  = '0;
          end else begin
            pcnt_d  = pcnt_inc;
          end
        end
      end
    endcase
    out_d = (state_d == ST_HIGH) || (state_d == ST_PEND_LO);
  end

  // Edge pulses are registered alongside out so they line up with its new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOW;
      pcnt_q  <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      out_q   <= out_d;
      rise_q  <= out_d & ~out_q;
      fall_q  <= ~out_d & out_q;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/threshold_comparator_seq.sv
// rtl/threshold_comparator_seq.sv - registered threshold comparator with persistence filter and rise counter.
// Optional CMP_HYSTERESIS_EN adds a hyst input that relaxes the release threshold while out=1.
module threshold_comparator_seq
  import cmp_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] THR_DEFAULT = WIDTH'(7),
  parameter int               PERSIST     = 3,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_word,
  input  logic [1:0]       mode,
  input  logic             thr_load,
  input  logic [WIDTH-1:0] thr_value,
  input  logic             cnt_clr,
`ifdef CMP_HYSTERESIS_EN
  input  logic [WIDTH-1:0] hyst,
`endif
  output logic             out,
  output logic             out_valid,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] evt_cnt
);

  logic [WIDTH-1:0] thr_q, thr_d;
  logic [WIDTH-1:0] thr_eff;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             raw;
  cmp_mode_t        mode_s;

  assign mode_s = cmp_mode_t'(mode);

`ifdef CMP_HYSTERESIS_EN
  logic [WIDTH:0]   thr_sum;
  logic [WIDTH-1:0] thr_lo, thr_hi;

  // Release threshold moves away from the trip point, clamped to the sample range.
  always_comb begin
    thr_sum = {1'b0, thr_q} + {1'b0, hyst};
    thr_lo  = (hyst > thr_q) ? '0 : (thr_q - hyst);
    thr_hi  = thr_sum[WIDTH] ? '1 : thr_sum[WIDTH-1:0];
    thr_eff = thr_q;
    if (out) begin
      case (mode_s)
        CMP_GT, CMP_GE: thr_eff = thr_lo;
        CMP_LT:         thr_eff = thr_hi;
        default:        thr_eff = thr_q;
      endcase
    end
  end
`else
  assign thr_eff = thr_q;
`endif

  assign raw = cmp_eval(CMP_MAX_W'(in_word), CMP_MAX_W'(thr_eff), mode_s);

  persist_filter #(
    .PERSIST (PERSIST)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .raw       (raw),
    .raw_valid (in_valid),
    .out       (out),
    .rise      (rise),
    .fall      (fall)
  );

  always_comb begin
    thr_d       = thr_load ? thr_value : thr_q;
    out_valid_d = out_valid_q | in_valid;
    evt_cnt_d   = evt_cnt_q;
    if (cnt_clr) begin
      evt_cnt_d = '0;
    end else if (rise && (evt_cnt_q != '1)) begin
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q       <= THR_DEFAULT;
      evt_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      thr_q       <= thr_d;
      evt_cnt_q   <= evt_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign evt_cnt   = evt_cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_threshold_comparator_seq.sv
// tb/tb_threshold_comparator_seq.sv - directed bench with a run-length reference model.
module tb_threshold_comparator_seq;

  localparam int PERSIST = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_word = '0;
  logic [1:0] mode = 2'b01;
  logic       thr_load = 1'b0;
  logic [3:0] thr_value = '0;
  logic       cnt_clr = 1'b0;
`ifdef CMP_HYSTERESIS_EN
  logic [3:0] hyst = '0;
`endif
  logic       out, out_valid, rise, fall;
  logic [7:0] evt_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  threshold_comparator_seq #(
    .WIDTH(4), .THR_DEFAULT(4'd7), .PERSIST(PERSIST), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .mode(mode),
    .thr_load(thr_load), .thr_value(thr_value), .cnt_clr(cnt_clr),
`ifdef CMP_HYSTERESIS_EN
    .hyst(hyst),
`endif
    .out(out), .out_valid(out_valid), .rise(rise), .fall(fall), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  // Model: out flips once PERSIST consecutive valid samples disagree with it.
  int  m_thr = 7;
  int  m_run = 0;
  int  m_cnt = 0;
  bit  m_out = 0, m_rise = 0, m_fall = 0, m_ov = 0;
  bit  started = 0;

  function automatic bit model_raw(int w, int t, int md, bit o, int h);
    int te;
    te = t;
    if (o && (md == 1 || md == 2)) te = (t - h < 0) ? 0 : t - h;
    if (o && md == 3) te = (t + h > 15) ? 15 : t + h;
    case (md)
      0: return w == t;
      1: return w > te;
      2: return w >= te;
      default: return w < te;
    endcase
  endfunction

  always @(posedge clk) begin
    bit r, prev;
    int h;
    h = 0;
`ifdef CMP_HYSTERESIS_EN
    h = int'(hyst);
`endif
    if (rst) begin
      m_thr = 7; m_run = 0; m_cnt = 0;
      m_out = 0; m_rise = 0; m_fall = 0; m_ov = 0;
      started = 1;
    end else begin
      if (cnt_clr) m_cnt = 0;
      else if (m_rise && m_cnt < 255) m_cnt = m_cnt + 1;
      prev = m_out;
      if (in_valid) begin
        m_ov = 1;
        r = model_raw(int'(in_word), m_thr, int'(mode), m_out, h);
        if (r != m_out) begin
          m_run = m_run + 1;
          if (m_run == PERSIST) begin
            m_out = r;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      m_rise = m_out && !prev;
      m_fall = !m_out && prev;
      if (thr_load) m_thr = int'(thr_value);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("out",       int'(out),       int'(m_out));
      check("rise",      int'(rise),      int'(m_rise));
      check("fall",      int'(fall),      int'(m_fall));
      check("out_valid", int'(out_valid), int'(m_ov));
      check("evt_cnt",   int'(evt_cnt),   m_cnt);
      check("rise_fall_excl", int'(rise & fall), 0);
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input int w);
    in_valid = 1'b1;
    in_word  = 4'(w);
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic samples3(input int w);
    sample(w); sample(w); sample(w);
  endtask

  initial begin
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    check("reset_out", int'(out), 0);
    check("reset_evt", int'(evt_cnt), 0);
    check("reset_ov",  int'(out_valid), 0);

    // 1: GT against 7, three exceeding samples
    mode = 2'b01;
    sample(8);
    check("t1_ov_after_first", int'(out_valid), 1);
    sample(9);
    check("t1_out_pending", int'(out), 0);
    sample(10);
    check("t1_out", int'(out), 1);
    check("t1_rise", int'(rise), 1);
    cyc(1);
    check("t1_evt", int'(evt_cnt), 1);

    // 2: a single 9 restarts the release run
    sample(3); sample(3); sample(9); sample(3); sample(3);
    check("t2_out_held", int'(out), 1);
    sample(3);
    check("t2_out_low", int'(out), 0);
    check("t2_fall", int'(fall), 1);
    cyc(1);
    check("t2_fall_once", int'(fall), 0);

    // 3: threshold load uses old value for the same-cycle sample
    thr_load = 1'b1; thr_value = 4'd2;
    sample(5);
    thr_load = 1'b0;
    sample(5); sample(5);
    check("t3_old_thr", int'(out), 0);
    sample(5);
    check("t3_out", int'(out), 1);

    // 4: EQ with gaps holding the run
    mode = 2'b00;
    thr_load = 1'b1; thr_value = 4'd7;
    sample(0);
    thr_load = 1'b0;
    sample(0); sample(0);
    check("t4_low", int'(out), 0);
    sample(7);
    cyc(4);
    sample(7);
    check("t4_pending", int'(out), 0);
    sample(7);
    check("t4_out", int'(out), 1);
    cyc(1);
    check("t4_evt", int'(evt_cnt), 3);

    // 5: saturate the rise counter, then clear coincident with a rise
    mode = 2'b01;
    for (int i = 0; i < 252; i++) begin
      samples3(0);
      samples3(8);
    end
    cyc(1);
    check("t5_evt_255", int'(evt_cnt), 255);
    samples3(0);
    samples3(8);
    cyc(1);
    check("t5_evt_sat", int'(evt_cnt), 255);
    samples3(0);
    samples3(8);
    check("t5_rise_now", int'(rise), 1);
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    check("t5_clr_wins", int'(evt_cnt), 0);

    // 6: reset in PEND_HI discards the partial run
    samples3(0);
    sample(8); sample(8);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t6_out", int'(out), 0);
    check("t6_ov", int'(out_valid), 0);
    check("t6_evt", int'(evt_cnt), 0);
    check("t6_rise", int'(rise), 0);
    sample(8);
    check("t6_no_carry", int'(out), 0);
    sample(8); sample(8);
    check("t6_thr_default", int'(out), 1);

`ifdef CMP_HYSTERESIS_EN
    hyst = 4'd2;
    sample(6); sample(6); sample(6);
    check("t7_hyst_hold", int'(out), 1);
    sample(5); sample(5);
    check("t7_hyst_pend", int'(out), 1);
    sample(5);
    check("t7_hyst_release", int'(out), 0);
    hyst = 4'd0;
`endif

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
